regfile_arbiter: RTL and testbench
==================================

# regfile_arbiter

Round-robin arbiter sharing a single DEPTH×WIDTH register array (default 32×8) between NREQ requesters. At most one access is performed per cycle. Reads return data one cycle after acceptance. A requester may lock the array for a burst of back-to-back accesses. The block sits between per-channel datapath units and the shared storage array, and owns that array.

## Interface
- NREQ, 4, number of requesters (2..8)
- DEPTH, 32, array entries
- WIDTH, 8, bits per entry
- MAX_BURST, 4, maximum consecutive locked grants to one requester (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_write  in  NREQ  1 = write, 0 = read
- req_lock  in  NREQ  keep grant after this beat (burst)
- req_addr  in  NREQ*AW  packed addresses, AW = $clog2(DEPTH)
- req_wdata  in  NREQ*WIDTH  packed write data
- req_ready  out  NREQ  one-hot or zero; accept when valid & ready
- rsp_valid  out  NREQ  one-hot read-data strobe
- rsp_rdata  out  WIDTH  read data, valid when rsp_valid ≠ 0
- busy  out  1  array locked by a burst

## Operation
- Reset, asynchronous:
  - All array entries are set to 0.
  - req_ready, rsp_valid and rsp_rdata are 0; busy is 0.
  - The priority pointer is set to NREQ-1, so requester 0 wins first.
  - The state machine enters ARB.
- Ready is combinational from req_valid and internal state. A requester must not make req_valid depend on req_ready.
- State ARB:
  - Grant the first valid requester scanning from ptr+1 upward, wrapping.
  - Drive req_ready for the granted requester only. If no requester is valid, req_ready = 0.
  - On an accepted beat, ptr ← granted index.
  - If req_lock is set on that beat, move to LOCK with owner ← index and cnt ← 1.
- State LOCK:
  - req_ready = owner bit only, and only when req_valid[owner] is set.
  - Every other requester stalls.
  - On an accepted beat, cnt increments.
  - Return to ARB when any of these holds: a beat is accepted with req_lock clear; an accepted beat brings cnt to MAX_BURST; req_valid[owner] drops.
  - The pointer stays at owner, so the next arbitration starts at owner+1.
- Write beat: array[addr] ← wdata at the clock edge.
- Read beat: the next cycle drives rsp_valid[index] = 1 and rsp_rdata = array[addr] as sampled at the accepting edge.
- Read of an address written in the same cycle is impossible, since there is a single port.
- Address ≥ DEPTH (non-power-of-2 DEPTH only):
  - A write is ignored.
  - A read responds with 0.
  - The handshake still completes normally.
- busy = (state == LOCK).

## Timing
- Accept to write-visible: 1 cycle. A read accepted on the following cycle returns the new value.
- Read latency: rsp_valid one cycle after the accepting edge. With back-to-back reads, rsp_valid is continuous.
- rsp_valid and rsp_rdata are registered. When no read was accepted in the previous cycle, they return to 0.
- Throughput is 1 beat per cycle. Worst-case wait for a valid requester that is not locked out is (NREQ-1)·MAX_BURST cycles.
- Reset asserted mid-burst or with a read in flight: outputs clear immediately. The pending response is dropped.

## Structure
- Package regfile_arb_pkg holds:
  - state enum {ARB, LOCK};
  - function rr_pick(valid, ptr), returning index plus found flag.
- Sub-module regfile_arb_mem: DEPTH×WIDTH array with one write port and one registered read port, and an asynchronous clear.
- Top level contains the FSM, pointer, burst counter and response steering.

## Test plan
- Reset, then a single read on requester 2 of addr 5 → req_ready = 0100 in the same cycle; the next cycle gives rsp_valid = 0100, rsp_rdata = 0.
- Write addr 3 = 8'hA5 on requester 1, then read addr 3 on requester 1 → rsp_rdata = 8'hA5 one cycle after the read is accepted.
- All four requesters valid, no lock, held for 8 cycles → grant order 0,1,2,3,0,1,2,3.
- Requester 1 locks for 6 beats with requesters 0 and 3 valid:
  - grants are 1,1,1,1 with busy = 1;
  - then 3, then 0;
  - the burst is truncated at MAX_BURST = 4.
- Requester 2 locks, then drops req_valid after 2 beats → busy falls the next cycle; requester 3 is granted.
- rst_n is pulled low during a LOCK burst with a read outstanding:
  - outputs are 0 immediately and no rsp_valid appears;
  - after release, requester 0 wins and a read of any address returns 0.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// ============================================================================
// regfile_arb_pkg : shared types and round-robin pick helper for regfile_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package regfile_arb_pkg;

  localparam int MAX_NREQ = 8;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit of valid strictly after ptr, wrapping within nreq entries.
  function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                    input logic [2:0]          ptr,
                                    input int                  nreq);
    pick_t r;
    int    j;
    r = '0;
    for (int i = 1; i <= MAX_NREQ; i++) begin
      j = (int'(ptr) + i) % nreq;
      if (i <= nreq && !r.found && valid[3'(j)]) begin
        r.found = 1'b1;
        r.idx   = 3'(j);
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_arbiter_if.sv
// ============================================================================
// regfile_arbiter_if : requester-side bus of the shared register-file arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

interface regfile_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_write;
  logic [NREQ-1:0]       req_lock;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_rdata;
  logic                  busy;

  modport master (
    output req_valid, req_write, req_lock, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_write, req_lock, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );

endinterface

`default_nettype wire

// File: rtl/regfile_arb_mem.sv
// ============================================================================
// regfile_arb_mem : DEPTH x WIDTH array, one write port, registered read port
// Revision 1.0
// ============================================================================
`default_nettype none

module regfile_arb_mem #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             we,
  input  wire logic [AW-1:0]    waddr,
  input  wire logic [WIDTH-1:0] wdata,
  input  wire logic             re,
  input  wire logic [AW-1:0]    raddr,
  output logic      [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Out-of-range addresses drop writes and read back as zero.
  always_comb begin
    mem_d = mem_q;
    if (we && int'(waddr) < DEPTH) mem_d[waddr] = wdata;
    rdata_d = '0;
    if (re && int'(raddr) < DEPTH) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/regfile_arbiter.sv
// ============================================================================
// regfile_arbiter : round-robin arbiter with burst lock over a shared regfile
// Revision 1.0
// ============================================================================
`default_nettype none

import regfile_arb_pkg::*;

module regfile_arbiter #(
  parameter int NREQ      = 4,
  parameter int DEPTH     = 32,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input wire logic          clk,
  input wire logic          rst_n,
  regfile_arbiter_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;

  pick_t            pick;
  logic             grant_ok;
  logic             acc;
  logic [PW-1:0]    acc_idx;
  logic [NREQ-1:0]  ready;
  logic             acc_write;
  logic [AW-1:0]    acc_addr;
  logic [WIDTH-1:0] acc_wdata;
  logic [WIDTH-1:0] mem_rdata;

  always_comb begin
    pick     = rr_pick(MAX_NREQ'(bus.req_valid), 3'(ptr_q), NREQ);
    grant_ok = pick.found && (int'(pick.idx) < NREQ);
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    acc      = 1'b0;
    acc_idx  = owner_q;
    // Ready is held low while reset is asserted so outputs clear immediately.
    if (rst_n) begin
      case (state_q)
        ARB: begin
          if (grant_ok) begin
            acc     = 1'b1;
            acc_idx = pick.idx[PW-1:0];
            ptr_d   = pick.idx[PW-1:0];
            if (bus.req_lock[pick.idx[PW-1:0]] && MAX_BURST > 1) begin
              state_d = LOCK;
              owner_d = pick.idx[PW-1:0];
              cnt_d   = CW'(1);
            end
          end
        end
        LOCK: begin
          if (bus.req_valid[owner_q]) begin
            acc   = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (!bus.req_lock[owner_q] || int'(cnt_q) + 1 >= MAX_BURST) state_d = ARB;
          end else begin
            state_d = ARB;
          end
        end
        default: state_d = ARB;
      endcase
    end
    ready       = acc ? (NREQ'(1) << acc_idx) : '0;
    acc_write   = bus.req_write[acc_idx];
    acc_addr    = bus.req_addr[int'(acc_idx)*AW +: AW];
    acc_wdata   = bus.req_wdata[int'(acc_idx)*WIDTH +: WIDTH];
    rsp_valid_d = (acc && !acc_write) ? ready : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      ptr_q       <= PW'(NREQ - 1);
      owner_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  regfile_arb_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (acc && acc_write),
    .waddr (acc_addr),
    .wdata (acc_wdata),
    .re    (acc && !acc_write),
    .raddr (acc_addr),
    .rdata (mem_rdata)
  );

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = mem_rdata;
  assign bus.busy      = (state_q == LOCK);

endmodule

`default_nettype wire

// File: tb/tb_regfile_arbiter.sv
// ============================================================================
// tb_regfile_arbiter : directed + random bench with a behavioural arbiter model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_regfile_arbiter;

  localparam int NREQ      = 4;
  localparam int DEPTH     = 32;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;
  localparam int AW        = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_arbiter_if #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) bus();

  regfile_arbiter #(
    .NREQ      (NREQ),
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [NREQ-1:0]  v, w, l;
  logic [AW-1:0]    a [NREQ];
  logic [WIDTH-1:0] d [NREQ];

  assign bus.req_valid = v;
  assign bus.req_write = w;
  assign bus.req_lock  = l;
  assign bus.req_addr  = {a[3], a[2], a[1], a[0]};
  assign bus.req_wdata = {d[3], d[2], d[1], d[0]};

  int tests = 0;
  int fails = 0;

  // Reference model: plain array plus rotating priority and burst bookkeeping.
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               m_ptr, m_owner, m_cnt;
  bit               m_locked;
  logic [NREQ-1:0]  m_rv;
  logic [WIDTH-1:0] m_rd;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_ptr = NREQ - 1; m_owner = 0; m_cnt = 0; m_locked = 0;
    m_rv = '0; m_rd = '0;
  endtask

  function automatic int model_grant();
    if (m_locked) return v[m_owner] ? m_owner : -1;
    for (int k = 1; k <= NREQ; k++)
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, clock, then advance the model.
  task automatic cycle(input int exp_g);
    int g;
    logic [NREQ-1:0]  nrv;
    logic [WIDTH-1:0] nrd;
    #1;
    g = model_grant();
    chk("ready", 32'(bus.req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    if (exp_g != -2) chk("grant_seq", 32'(bus.req_ready), (exp_g < 0) ? 32'd0 : (32'd1 << exp_g));
    chk("busy", 32'(bus.busy), 32'(m_locked));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rv));
    chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_rd));
    @(posedge clk);
    nrv = '0; nrd = '0;
    if (g >= 0) begin
      if (w[g]) m_mem[a[g]] = d[g];
      else begin nrv[g] = 1'b1; nrd = m_mem[a[g]]; end
      m_ptr = g;
      if (!m_locked) begin
        if (l[g] && MAX_BURST > 1) begin m_locked = 1; m_owner = g; m_cnt = 1; end
      end else begin
        m_cnt++;
        if (!l[g] || m_cnt == MAX_BURST) m_locked = 0;
      end
    end else if (m_locked) begin
      m_locked = 0;
    end
    m_rv = nrv; m_rd = nrd;
    #1;
  endtask

  initial begin
    v = '0; w = '0; l = '0;
    for (int i = 0; i < NREQ; i++) begin a[i] = '0; d[i] = '0; end
    model_reset();

    // Reset state
    #12;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read, requester 2, addr 5
    v = 4'b0100; w = '0; a[2] = 5'd5;
    cycle(2);
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h4);
    chk("t1_rdata", 32'(bus.rsp_rdata), 32'h0);
    v = '0;
    cycle(-1);

    // Write then read back on requester 1
    v = 4'b0010; w = 4'b0010; a[1] = 5'd3; d[1] = 8'hA5;
    cycle(1);
    w = '0;
    cycle(1);
    chk("t2_rdata", 32'(bus.rsp_rdata), 32'hA5);
    v = '0;
    cycle(-1);

    // Rotation across all four requesters
    v = 4'b1000; a[3] = 5'd0;
    cycle(3);
    v = 4'b1111;
    for (int i = 0; i < NREQ; i++) a[i] = AW'(i + 8);
    for (int k = 0; k < 8; k++) cycle(k % NREQ);
    v = '0;

    // Burst of requester 1 truncated at MAX_BURST, others waiting
    v = 4'b0001;
    cycle(0);
    v = 4'b1011; l = 4'b0010; a[1] = 5'd3;
    for (int k = 0; k < 4; k++) begin
      cycle(1);
      chk("t4_busy", 32'(bus.busy), (k < 3) ? 32'd1 : 32'd0);
    end
    cycle(3);
    v[3] = 1'b0;
    cycle(0);
    v[0] = 1'b0;
    cycle(1);
    cycle(1);
    v = '0;
    cycle(-1);
    l = '0;

    // Requester 2 locks, drops valid after two beats
    v = 4'b1100; l = 4'b0100; a[2] = 5'd7; a[3] = 5'd9;
    cycle(2);
    cycle(2);
    v = 4'b1000;
    cycle(-1);
    chk("t5_busy_fall", 32'(bus.busy), 32'd0);
    cycle(3);
    v = '0; l = '0;

    // Reset during a burst with a read in flight
    v = 4'b0001; l = 4'b0001; w = '0; a[0] = 5'd3;
    cycle(0);
    cycle(0);
    rst_n = 1'b0;
    #1;
    chk("t6_ready", 32'(bus.req_ready), 32'd0);
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t6_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    model_reset();
    @(posedge clk); #1;
    chk("t6_hold_rv", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b1; l = '0;
    cycle(0);
    v = '0;
    cycle(-1);
    chk("t6_cleared", 32'(bus.rsp_rdata), 32'd0);

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      v = 4'($urandom);
      w = 4'($urandom);
      l = 4'($urandom) & 4'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        a[i] = AW'($urandom_range(0, 7));
        d[i] = WIDTH'($urandom);
      end
      cycle(-2);
    end
    v = '0; w = '0; l = '0;
    cycle(-2);
    cycle(-2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
